// File: rtl/otp_ctrl_init_seq.sv
// OTP controller init sequencer: AST power-up handshake, then per-partition init.
// Terminal in DoneSt/ErrorSt until reset; every output comes straight from a flop.
module otp_ctrl_init_seq #(
  parameter int NumPart        = 7,
  parameter int PwrSeqTimeout  = 255,
  parameter int OtpPwrSeqWidth = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      pwr_otp_init_req_i,
  output logic                      pwr_otp_init_done_o,
  output logic                      pwr_otp_idle_o,
  output logic [OtpPwrSeqWidth-1:0] ast_pwr_seq_o,
  input  logic [OtpPwrSeqWidth-1:0] ast_pwr_seq_h_i,
  output logic [NumPart-1:0]        part_init_req_o,
  input  logic [NumPart-1:0]        part_init_done_i,
  input  logic [NumPart-1:0]        part_init_err_i,
  output logic                      init_err_o
);

  // Sparse codes with pairwise Hamming distance >= 3.
  typedef enum logic [5:0] {
    IdleSt     = 6'b000000,
    PwrUp0St   = 6'b000111,
    PwrUp1St   = 6'b011001,
    PartInitSt = 6'b101010,
    DoneSt     = 6'b110100,
    ErrorSt    = 6'b111111
  } state_e;

  localparam logic [OtpPwrSeqWidth-1:0] SeqStep0   = OtpPwrSeqWidth'(1);
  localparam logic [OtpPwrSeqWidth-1:0] SeqStep1   = OtpPwrSeqWidth'(3);
  localparam logic [7:0]                TimeoutVal = 8'(PwrSeqTimeout);

  typedef struct packed {
    logic                      done;
    logic                      err;
    logic                      idle;
    logic [OtpPwrSeqWidth-1:0] ast;
  } out_t;

  // Plain vector so a corrupted code stays representable and lands in the default arm.
  logic [5:0]         r_state;
  logic [7:0]         r_cnt;
  logic [NumPart-1:0] r_done;
  logic [NumPart-1:0] r_req;
  out_t               r_out;

  logic [7:0]         w_cnt_inc;
  logic               w_timeout;
  logic               w_part_err;
  logic [NumPart-1:0] w_done_seen;
  logic               w_all_done;

  function automatic out_t stateOut(input state_e s);
    out_t o;
    o = '0;
    case (s)
      IdleSt:               o.idle = 1'b1;
      PwrUp0St:             o.ast  = SeqStep0;
      PwrUp1St, PartInitSt: o.ast  = SeqStep1;
      DoneSt: begin
        o.ast  = SeqStep1;
        o.done = 1'b1;
        o.idle = 1'b1;
      end
      default: begin
        o.done = 1'b1;
        o.err  = 1'b1;
        o.idle = 1'b1;
      end
    endcase
    return o;
  endfunction

  // The wait counts the current cycle, so a step lasts at most PwrSeqTimeout cycles.
  assign w_cnt_inc   = r_cnt + 8'd1;
  assign w_timeout   = (w_cnt_inc == TimeoutVal);
  assign w_part_err  = |(part_init_done_i & part_init_err_i);
  assign w_done_seen = r_done | part_init_done_i;
  assign w_all_done  = &w_done_seen;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IdleSt;
      r_cnt   <= '0;
      r_done  <= '0;
      r_req   <= '0;
      r_out   <= stateOut(IdleSt);
    end else begin
      case (r_state)
        IdleSt: begin
          if (pwr_otp_init_req_i) begin
            r_state <= PwrUp0St;
            r_out   <= stateOut(PwrUp0St);
            r_cnt   <= '0;
            r_done  <= '0;
          end
        end
        // Acknowledge is checked before the timeout so a last-cycle ack still wins.
        PwrUp0St: begin
          if (ast_pwr_seq_h_i == SeqStep0) begin
            r_state <= PwrUp1St;
            r_out   <= stateOut(PwrUp1St);
            r_cnt   <= '0;
          end else if (w_timeout) begin
            r_state <= ErrorSt;
            r_out   <= stateOut(ErrorSt);
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        PwrUp1St: begin
          if (ast_pwr_seq_h_i == SeqStep1) begin
            r_state <= PartInitSt;
            r_out   <= stateOut(PartInitSt);
            r_req   <= '1;
          end else if (w_timeout) begin
            r_state <= ErrorSt;
            r_out   <= stateOut(ErrorSt);
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        PartInitSt: begin
          r_done <= w_done_seen;
          if (w_part_err) begin
            r_state <= ErrorSt;
            r_out   <= stateOut(ErrorSt);
            r_req   <= '0;
          end else if (w_all_done) begin
            r_state <= DoneSt;
            r_out   <= stateOut(DoneSt);
            r_req   <= '0;
          end else begin
            r_req <= ~w_done_seen;
          end
        end
        DoneSt, ErrorSt: begin
        end
        default: begin
          r_state <= ErrorSt;
          r_out   <= stateOut(ErrorSt);
          r_req   <= '0;
        end
      endcase
    end
  end

  assign pwr_otp_init_done_o = r_out.done;
  assign init_err_o          = r_out.err;
  assign pwr_otp_idle_o      = r_out.idle;
  assign ast_pwr_seq_o       = r_out.ast;
  assign part_init_req_o     = r_req;

endmodule

// File: tb/tb_otp_ctrl_init_seq.sv
// Randomized scoreboard bench for otp_ctrl_init_seq: a timeline model predicts when and
// how the sequence terminates; a monitor checks each terminal event as the DUT shows it.
module tb_otp_ctrl_init_seq;

  localparam int NumPart = 7;
  localparam int Timeout = 4;

  logic                clk;
  logic                rst;
  logic                req;
  logic                doneO;
  logic                idleO;
  logic                errO;
  logic [1:0]          astO;
  logic [1:0]          astH;
  logic [NumPart-1:0]  partReq;
  logic [NumPart-1:0]  partDone;
  logic [NumPart-1:0]  partErr;

  typedef struct {
    int cyc;
    bit err;
  } exp_t;

  exp_t sbQ[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   doneAt [NumPart];

  otp_ctrl_init_seq #(
    .NumPart(NumPart),
    .PwrSeqTimeout(Timeout),
    .OtpPwrSeqWidth(2)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .pwr_otp_init_req_i(req),
    .pwr_otp_init_done_o(doneO),
    .pwr_otp_idle_o(idleO),
    .ast_pwr_seq_o(astO),
    .ast_pwr_seq_h_i(astH),
    .part_init_req_o(partReq),
    .part_init_done_i(partDone),
    .part_init_err_i(partErr),
    .init_err_o(errO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0d expected=%0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Monitor: every rising done is a terminal event that must match the head of the queue.
  initial begin
    exp_t e;
    logic prevDone;
    prevDone = 1'b0;
    forever begin
      @(negedge clk);
      if (doneO === 1'b1 && prevDone !== 1'b1) begin
        if (sbQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected done: actual=1 expected=0 (cycle %0d)", cyc);
        end else begin
          e = sbQ.pop_front();
          checkOutput("terminal cycle", 32'(cyc), 32'(e.cyc));
          checkOutput("terminal err", 32'(errO), 32'(e.err));
          checkOutput("terminal ast", 32'(astO), e.err ? 32'd0 : 32'd3);
          checkOutput("terminal idle", 32'(idleO), 32'd1);
          checkOutput("terminal part req", 32'(partReq), 32'd0);
        end
      end
      prevDone = doneO;
    end
  end

  // Runs one init sequence. d0/d1: cycle of each step in which AST acks (>= Timeout means never);
  // doneAt[]: PartInit cycle of each partition's done pulse; errPart: partition flagging an error
  // with its done (-1 none); abortC: PartInit cycle in which reset is asserted (-1 none).
  task automatic applyStimulus(input int d0, input int d1, input int errPart, input int abortC);
    int   ep1, epi, lRel, termC, maxC, probeC, c0, c, idleN;
    bit   expErr, willAbort;
    logic [NumPart-1:0] expReq;
    exp_t e;

    maxC = 0;
    for (int i = 0; i < NumPart; i++) if (doneAt[i] > maxC) maxC = doneAt[i];
    ep1 = -1; epi = -1; termC = 0;
    if (d0 >= Timeout) begin
      expErr = 1'b1;
      lRel   = Timeout;
    end else begin
      ep1 = d0 + 1;
      if (d1 >= Timeout) begin
        expErr = 1'b1;
        lRel   = ep1 + Timeout;
      end else begin
        epi = ep1 + d1 + 1;
        if (errPart >= 0) begin
          expErr = 1'b1;
          termC  = doneAt[errPart];
        end else begin
          expErr = 1'b0;
          termC  = maxC;
        end
        lRel = epi + termC + 1;
      end
    end
    willAbort = (abortC >= 0 && epi >= 0 && abortC <= termC);
    probeC    = (epi >= 0) ? int'($urandom_range(termC, 0)) : -1;

    idleN = int'($urandom_range(3, 1));
    for (int k = 0; k < idleN; k++) begin
      @(negedge clk);
      req      = 1'b0;
      astH     = 2'($urandom);
      partDone = NumPart'($urandom);
      partErr  = NumPart'($urandom);
    end
    checkOutput("idle before req", 32'(idleO), 32'd1);
    checkOutput("ast in idle", 32'(astO), 32'd0);

    @(negedge clk);
    req = 1'b1;
    c0  = cyc;
    if (!willAbort) begin
      e.cyc = c0 + 1 + lRel;
      e.err = expErr;
      sbQ.push_back(e);
    end

    for (int r = 0; r < lRel; r++) begin
      @(negedge clk);
      if (r == 0) begin
        checkOutput("ast in PwrUp0", 32'(astO), 32'd1);
        checkOutput("idle in PwrUp0", 32'(idleO), 32'd0);
      end
      if (ep1 >= 0 && r == ep1) checkOutput("ast in PwrUp1", 32'(astO), 32'd3);
      if (epi >= 0 && r == epi + probeC) begin
        for (int i = 0; i < NumPart; i++) expReq[i] = (doneAt[i] >= probeC);
        checkOutput("part req in PartInit", 32'(partReq), 32'(expReq));
        checkOutput("ast in PartInit", 32'(astO), 32'd3);
      end
      if (willAbort && r == epi + abortC) begin
        rst      = 1'b1;
        partDone = '0;
        break;
      end
      if (ep1 < 0 || r < ep1) begin
        if (ep1 >= 0 && r == d0) astH = 2'b01;
        else case ($urandom_range(2, 0))
          0:       astH = 2'b00;
          1:       astH = 2'b10;
          default: astH = 2'b11;
        endcase
        partDone = NumPart'($urandom);
        partErr  = NumPart'($urandom);
      end else if (epi < 0 || r < epi) begin
        astH     = (epi >= 0 && r - ep1 == d1) ? 2'b11 : 2'($urandom_range(2, 0));
        partDone = NumPart'($urandom);
        partErr  = NumPart'($urandom);
      end else begin
        c    = r - epi;
        astH = 2'b11;
        for (int i = 0; i < NumPart; i++) begin
          partDone[i] = (doneAt[i] == c);
          partErr[i]  = partDone[i] ? (i == errPart) : 1'($urandom);
        end
      end
    end

    if (!willAbort) begin
      for (int h = 0; h < 4; h++) begin
        @(negedge clk);
        req      = 1'($urandom);
        astH     = 2'($urandom);
        partDone = NumPart'($urandom);
        partErr  = NumPart'($urandom);
      end
      checkOutput("done held", 32'(doneO), 32'd1);
      checkOutput("err held", 32'(errO), 32'(expErr));
      checkOutput("scoreboard drain", 32'(sbQ.size()), 32'd0);
      sbQ.delete();
      @(negedge clk);
      rst = 1'b1;
    end

    @(negedge clk);
    checkOutput("reset done", 32'(doneO), 32'd0);
    checkOutput("reset err", 32'(errO), 32'd0);
    checkOutput("reset idle", 32'(idleO), 32'd1);
    checkOutput("reset ast", 32'(astO), 32'd0);
    checkOutput("reset part req", 32'(partReq), 32'd0);
    rst = 1'b0;
    req = 1'b0;
  endtask

  initial begin
    exp_t e;
    rst = 1'b1; req = 1'b0; astH = '0; partDone = '0; partErr = '0;
    repeat (3) @(negedge clk);
    checkOutput("power-on done", 32'(doneO), 32'd0);
    checkOutput("power-on idle", 32'(idleO), 32'd1);
    checkOutput("power-on part req", 32'(partReq), 32'd0);
    rst = 1'b0;

    // Nominal run with staggered partition completion.
    doneAt = '{1, 4, 2, 7, 3, 5, 6};
    applyStimulus(2, 2, -1, -1);
    // AST never acknowledges the first step.
    applyStimulus(Timeout + 3, 0, -1, -1);
    // Part 3 errors in the same cycle part 6 would complete the set.
    doneAt = '{1, 2, 3, 8, 4, 5, 8};
    applyStimulus(1, 1, 3, -1);
    // Acks in the last cycle before the timeout on both steps.
    doneAt = '{0, 0, 1, 1, 2, 2, 3};
    applyStimulus(Timeout - 1, Timeout - 1, -1, -1);
    // Second step times out.
    applyStimulus(1, Timeout + 2, -1, -1);
    // Reset with four of seven partitions done, then a full re-run.
    doneAt = '{0, 1, 2, 3, 9, 9, 9};
    applyStimulus(1, 1, -1, 5);
    applyStimulus(2, 0, -1, -1);

    // Corrupt the state register while idle.
    @(negedge clk);
    force dut.r_state = 6'b010101;
    e.cyc = cyc + 1;
    e.err = 1'b1;
    sbQ.push_back(e);
    @(posedge clk);
    #1 release dut.r_state;
    @(negedge clk);
    @(negedge clk);
    checkOutput("fault err held", 32'(errO), 32'd1);
    checkOutput("fault scoreboard drain", 32'(sbQ.size()), 32'd0);
    sbQ.delete();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("fault reset idle", 32'(idleO), 32'd1);

    for (int n = 0; n < 40; n++) begin
      int d0, d1, ep;
      d0 = ($urandom_range(7, 0) == 0) ? Timeout + int'($urandom_range(2, 0)) : int'($urandom_range(Timeout - 1, 0));
      d1 = ($urandom_range(7, 0) == 0) ? Timeout + int'($urandom_range(2, 0)) : int'($urandom_range(Timeout - 1, 0));
      for (int i = 0; i < NumPart; i++) doneAt[i] = int'($urandom_range(10, 0));
      ep = ($urandom_range(3, 0) == 0) ? int'($urandom_range(NumPart - 1, 0)) : -1;
      applyStimulus(d0, d1, ep, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/otp_ctrl_init_seq.md
OTP_CTRL_INIT_SEQ -- requirements
Module: otp_ctrl_init_seq

Interface
REQ-001 Parameter NumPart, default 7, number of partitions initialised after macro power-up.
REQ-002 Parameter PwrSeqTimeout, default 255, maximum cycles to wait in each AST power-sequence step; valid range 1..255.
REQ-003 Parameter OtpPwrSeqWidth, default 2, width of the AST power-sequence buses.
REQ-004 clk_i  input  1  sole clock; all logic on rising edge.
REQ-005 rst_i  input  1  synchronous, active-high reset.
REQ-006 pwr_otp_init_req_i  input  1  init request from power manager (pwr_otp_init_req_t.init); level.
REQ-007 pwr_otp_init_done_o  output  1  init complete (pwr_otp_init_rsp_t.done).
REQ-008 pwr_otp_idle_o  output  1  controller idle (otp_pwr_state_t.idle).
REQ-009 ast_pwr_seq_o  output  OtpPwrSeqWidth  power-sequence request to AST (otp_ast_req_t.pwr_seq).
REQ-010 ast_pwr_seq_h_i  input  OtpPwrSeqWidth  power-sequence acknowledge from AST (otp_ast_rsp_t.pwr_seq_h).
REQ-011 part_init_req_o  output  NumPart  per-partition init request.
REQ-012 part_init_done_i  input  NumPart  per-partition init done pulse or level.
REQ-013 part_init_err_i  input  NumPart  per-partition init error, qualified by the matching done bit.
REQ-014 init_err_o  output  1  sticky error: timeout, partition error or illegal state.

Function
REQ-015 FSM states: IdleSt, PwrUp0St, PwrUp1St, PartInitSt, DoneSt, ErrorSt; encoding is sparse, min Hamming distance 3.
REQ-016 IdleSt: pwr_otp_init_req_i=1 sampled -> PwrUp0St next cycle; otherwise stay.
REQ-017 PwrUp0St: ast_pwr_seq_o=2'b01; ast_pwr_seq_h_i==2'b01 -> PwrUp1St.
REQ-018 PwrUp1St: ast_pwr_seq_o=2'b11; ast_pwr_seq_h_i==2'b11 -> PartInitSt.
REQ-019 ast_pwr_seq_o=2'b11 in PartInitSt and DoneSt; 2'b00 in IdleSt and ErrorSt.
REQ-020 8-bit timeout counter cleared on entry to PwrUp0St and PwrUp1St, increments each cycle in those states; acknowledge missing when counter == PwrSeqTimeout -> ErrorSt.
REQ-021 Acknowledge arriving in the same cycle the counter hits PwrSeqTimeout: acknowledge wins, no error.
REQ-022 PartInitSt: part_init_req_o[i]=1 until done bit i captured; each done is captured into a sticky NumPart-bit register; request bit i drops the cycle after capture.
REQ-023 All sticky done bits set and no error -> DoneSt; sticky register clears on entry to PwrUp0St.
REQ-024 Any part_init_err_i[i] with part_init_done_i[i]=1 in PartInitSt -> ErrorSt; error takes priority over completion in the same cycle.
REQ-025 part_init_done_i bits outside PartInitSt are ignored.
REQ-026 DoneSt: pwr_otp_init_done_o=1, held until reset; deassertion or reassertion of pwr_otp_init_req_i ignored.
REQ-027 ErrorSt: terminal until reset; init_err_o=1; pwr_otp_init_done_o=1 so the power manager is not stalled; part_init_req_o=0.
REQ-028 Any unencoded state value -> ErrorSt next cycle.
REQ-029 pwr_otp_idle_o=1 in IdleSt, DoneSt and ErrorSt; 0 otherwise.
REQ-030 All outputs registered or decoded from registered state only; no combinational input-to-output path.

Reset
REQ-031 rst_i=1 at a clock edge -> IdleSt, counter=0, sticky done=0; init_err_o=0 and pwr_otp_init_done_o=0.
REQ-032 Reset outputs: ast_pwr_seq_o=0, part_init_req_o=0, pwr_otp_idle_o=1.
REQ-033 Reset asserted mid-sequence, in any state, aborts to these values in the following cycle.
REQ-034 Reset has priority over all other inputs.

Verification
REQ-035 Nominal: NumPart=7, init req=1, AST acks after 3 cycles per step, partitions done at staggered cycles -> done_o=1, init_err_o=0, ast_pwr_seq_o=2'b11, idle_o=1.
REQ-036 Timeout: PwrSeqTimeout=4, ast_pwr_seq_h_i held 0 -> ErrorSt entered 4 cycles after PwrUp0St entry; init_err_o=1, done_o=1, ast_pwr_seq_o=0.
REQ-037 Partition error: part 3 asserts done with err=1 in the same cycle part 6 completes the set -> ErrorSt, not DoneSt.
REQ-038 Boundary ack: ack in the same cycle the counter equals PwrSeqTimeout -> PwrUp1St, no error.
REQ-039 Reset mid-PartInitSt with 4 of 7 parts done -> next cycle part_init_req_o=0, sticky done=0, idle_o=1; a new request re-runs the full sequence.
REQ-040 State-register fault injection (force an illegal encoding) -> ErrorSt next cycle, init_err_o=1.
